// File: rtl/alu_op_sequencer.sv
// Control sequencer for one register-register ALU instruction on the shared-bus
// data path: Y load, ALU execute, Z writeback (LO/HI for 64-bit results).
module alu_op_sequencer #(
  parameter logic [4:0] OP_MUL = 5'b01110,
  parameter logic [4:0] OP_DIV = 5'b01111
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  op_in,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  output logic        busy,
  output logic        done,
  output logic [4:0]  op,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        ZHighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        LOin,
  output logic        HIin
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_Y = 3'd1,
    S_EXEC   = 3'd2,
    S_WB_LO  = 3'd3,
    S_WB_HI  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_op;
  logic [3:0] r_ra;
  logic [3:0] r_rb;
  logic [3:0] r_rc;
  logic       r_wide;
  logic       w_accept;
  logic       w_wide_in;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_wide_in = (op_in == OP_MUL) || (op_in == OP_DIV);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; clear is checked first, making the reset synchronous.
  always_ff @(posedge Clock) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
      r_wide  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= op_in;
        r_ra   <= ra;
        r_rb   <= rb;
        r_rc   <= rc;
        r_wide <= w_wide_in;
      end
    end
  end

  // NOTE: every output is given a default before the case so no path through
  // this block leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_next   = S_IDLE;
    busy     = 1'b1;
    done     = 1'b0;
    op       = 5'b00000;
    Rout     = '0;
    Rin      = '0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    ZHighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;

    case (r_state)
      S_IDLE: begin
        busy   = 1'b0;
        w_next = start ? S_LOAD_Y : S_IDLE;
      end
      S_LOAD_Y: begin
        Rout   = onehot16(r_rb);
        Yin    = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        Rout    = onehot16(r_rc);
        op      = r_op;
        Zlowin  = 1'b1;
        ZHighin = r_wide;
        w_next  = S_WB_LO;
      end
      S_WB_LO: begin
        Zlowout = 1'b1;
        if (r_wide) begin
          LOin   = 1'b1;
          w_next = S_WB_HI;
        end else begin
          Rin    = onehot16(r_ra);
          w_next = S_DONE;
        end
      end
      S_WB_HI: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      // Unused encodings present all-zero outputs and fall back to IDLE.
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: expected per-cycle strobe vectors are
// queued at issue time and a negedge monitor compares them; a small data path model checks results.
module tb_alu_op_sequencer;

  localparam logic [4:0] OP_OR  = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_UNK = 5'b11111;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [4:0]  op;
    logic [15:0] rout;
    logic [15:0] rin;
    logic        yin;
    logic        zlowin;
    logic        zhighin;
    logic        zlowout;
    logic        zhighout;
    logic        loin;
    logic        hiin;
  } outv_t;

  logic        Clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  op_in;
  logic [3:0]  ra, rb, rc;
  logic        busy, done, Yin, Zlowin, ZHighin, Zlowout, Zhighout, LOin, HIin;
  logic [4:0]  op;
  logic [15:0] Rout, Rin;

  alu_op_sequencer #(.OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
    .Clock(Clock), .clear(clear), .start(start), .op_in(op_in),
    .ra(ra), .rb(rb), .rc(rc), .busy(busy), .done(done), .op(op),
    .Rout(Rout), .Rin(Rin), .Yin(Yin), .Zlowin(Zlowin), .ZHighin(ZHighin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin)
  );

  always #5 Clock = ~Clock;

  outv_t act;
  assign act = '{busy, done, op, Rout, Rin, Yin, Zlowin, ZHighin,
                 Zlowout, Zhighout, LOin, HIin};

  // ---------------- data path model ----------------
  logic [31:0] r_file [16];
  logic [31:0] y_reg, lo_reg, hi_reg, bus;
  logic [63:0] z_reg, alu_res;
  logic        pl_we = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  function automatic logic [63:0] alu_f(input logic [4:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    case (o)
      OP_OR:   return {32'd0, a | b};
      OP_ADD:  return {32'd0, a + b};
      OP_MUL:  return 64'(a) * 64'(b);
      OP_DIV:  return (b == 0) ? 64'd0 : {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  always_comb begin
    bus = '0;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus |= r_file[i];
    if (Zlowout)  bus |= z_reg[31:0];
    if (Zhighout) bus |= z_reg[63:32];
  end
  assign alu_res = alu_f(op, y_reg, bus);

  always @(posedge Clock) begin
    if (Yin)     y_reg        <= bus;
    if (Zlowin)  z_reg[31:0]  <= alu_res[31:0];
    if (ZHighin) z_reg[63:32] <= alu_res[63:32];
    if (LOin)    lo_reg       <= bus;
    if (HIin)    hi_reg       <= bus;
    for (int i = 0; i < 16; i++) if (Rin[i]) r_file[i] <= bus;
    if (pl_we)   r_file[pl_idx] <= pl_val;
  end

  // ---------------- scoreboard ----------------
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    mon_en   = 1'b0;
  string cur_test = "reset";
  outv_t exp_q[$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s [%s]: got %h expected %h", name, cur_test, actual, expected);
  endtask

  function automatic outv_t mk(input logic bsy, input logic dn, input logic [4:0] o,
                               input logic [15:0] ro, input logic [15:0] ri,
                               input logic [6:0] strobes);
    outv_t v;
    v = '{bsy, dn, o, ro, ri, strobes[6], strobes[5], strobes[4], strobes[3],
          strobes[2], strobes[1], strobes[0]};
    return v;
  endfunction

  // strobes order: {Yin, Zlowin, ZHighin, Zlowout, Zhighout, LOin, HIin}
  task automatic push_plain(input logic [4:0] o, input logic [3:0] d, input logic [3:0] s1,
                            input logic [3:0] s2);
    exp_q.push_back(mk(1, 0, 5'd0, 16'(1) << s1, 16'd0, 7'b1000000));
    exp_q.push_back(mk(1, 0, o,    16'(1) << s2, 16'd0, 7'b0100000));
    exp_q.push_back(mk(1, 0, 5'd0, 16'd0, 16'(1) << d,  7'b0001000));
    exp_q.push_back(mk(1, 1, 5'd0, 16'd0, 16'd0,        7'b0000000));
  endtask

  task automatic push_wide(input logic [4:0] o, input logic [15:0] ro_b, input logic [15:0] ro_c);
    exp_q.push_back(mk(1, 0, 5'd0, ro_b,  16'd0, 7'b1000000));
    exp_q.push_back(mk(1, 0, o,    ro_c,  16'd0, 7'b0110000));
    exp_q.push_back(mk(1, 0, 5'd0, 16'd0, 16'd0, 7'b0001010));
    exp_q.push_back(mk(1, 0, 5'd0, 16'd0, 16'd0, 7'b0000101));
    exp_q.push_back(mk(1, 1, 5'd0, 16'd0, 16'd0, 7'b0000000));
  endtask

  always @(negedge Clock) begin
    if (mon_en) begin
      if (exp_q.size() > 0) check("seq_vec", 64'(act), 64'(exp_q.pop_front()));
      else                  check("idle_vec", 64'(act), 64'd0);
      check("bus_rule", 64'(($countones(Rout) <= 1) && ($countones(Rin) <= 1) &&
                            ((int'(|Rout) + int'(Zlowout) + int'(Zhighout)) <= 1)), 64'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pl_we = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge Clock); #1;
    pl_we = 1'b0;
  endtask

  task automatic issue(input logic [4:0] o, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2);
    op_in = o; ra = d; rb = s1; rc = s2; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(posedge Clock); #1;
      n++;
    end
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_checks++;
      $display("FAIL drain_timeout [%s]: got %0d pending, busy=%b required 0 pending, idle",
               cur_test, exp_q.size(), busy);
      exp_q.delete();
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; op_in = '0; ra = '0; rb = '0; rc = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_outputs", 64'(act), 64'd0);
    clear  = 1'b1;
    mon_en = 1'b1;

    preload(4'd1, 32'd0);  preload(4'd2, 32'd5);  preload(4'd3, 32'd12);
    preload(4'd4, 32'd99); preload(4'd5, 32'd3);  preload(4'd7, 32'd11);

    cur_test = "or";
    issue(OP_OR, 4'd1, 4'd3, 4'd2);
    exp_q.push_back(mk(1, 0, 5'd0,  16'h0008, 16'h0000, 7'b1000000));
    exp_q.push_back(mk(1, 0, OP_OR, 16'h0004, 16'h0000, 7'b0100000));
    exp_q.push_back(mk(1, 0, 5'd0,  16'h0000, 16'h0002, 7'b0001000));
    exp_q.push_back(mk(1, 1, 5'd0,  16'h0000, 16'h0000, 7'b0000000));
    wait_drain(20);
    check("or_r1", 64'(r_file[1]), 64'd13);

    cur_test = "start_while_busy";
    issue(OP_OR, 4'd6, 4'd3, 4'd2);
    push_plain(OP_OR, 4'd6, 4'd3, 4'd2);
    @(posedge Clock); #1;
    op_in = OP_ADD; ra = 4'd4; rb = 4'd5; rc = 4'd5; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    wait_drain(20);
    check("busy_r6", 64'(r_file[6]), 64'd13);
    check("busy_r4_kept", 64'(r_file[4]), 64'd99);

    cur_test = "reset_mid_op";
    issue(OP_ADD, 4'd7, 4'd3, 4'd2);
    exp_q.push_back(mk(1, 0, 5'd0,   16'h0008, 16'h0000, 7'b1000000));
    exp_q.push_back(mk(1, 0, OP_ADD, 16'h0004, 16'h0000, 7'b0100000));
    @(posedge Clock); #1;
    clear = 1'b0;
    @(posedge Clock); #1;
    clear = 1'b1;
    check("abort_outputs", 64'(act), 64'd0);
    repeat (4) @(posedge Clock);
    #1;
    check("abort_r7_kept", 64'(r_file[7]), 64'd11);
    wait_drain(20);

    cur_test = "alias";
    issue(OP_ADD, 4'd5, 4'd5, 4'd5);
    push_plain(OP_ADD, 4'd5, 4'd5, 4'd5);
    wait_drain(20);
    check("alias_r5", 64'(r_file[5]), 64'd6);

    cur_test = "unknown_op_edges";
    issue(OP_UNK, 4'd15, 4'd0, 4'd15);
    exp_q.push_back(mk(1, 0, 5'd0,   16'h0001, 16'h0000, 7'b1000000));
    exp_q.push_back(mk(1, 0, OP_UNK, 16'h8000, 16'h0000, 7'b0100000));
    exp_q.push_back(mk(1, 0, 5'd0,   16'h0000, 16'h8000, 7'b0001000));
    exp_q.push_back(mk(1, 1, 5'd0,   16'h0000, 16'h0000, 7'b0000000));
    wait_drain(20);

    cur_test = "back_to_back";
    preload(4'd1, 32'd0);
    op_in = OP_OR; ra = 4'd1; rb = 4'd3; rc = 4'd2; start = 1'b1;
    @(posedge Clock); #1;
    op_in = OP_ADD; ra = 4'd8;
    push_plain(OP_OR, 4'd1, 4'd3, 4'd2);
    exp_q.push_back('0);
    push_plain(OP_ADD, 4'd8, 4'd3, 4'd2);
    repeat (5) @(posedge Clock);
    #1;
    start = 1'b0;
    wait_drain(20);
    check("b2b_r1", 64'(r_file[1]), 64'd13);
    check("b2b_r8", 64'(r_file[8]), 64'd17);

    cur_test = "mul";
    preload(4'd3, 32'd6); preload(4'd2, 32'd7); preload(4'd9, 32'd77);
    issue(OP_MUL, 4'd9, 4'd3, 4'd2);
    push_wide(OP_MUL, 16'h0008, 16'h0004);
    wait_drain(20);
    check("mul_lo", 64'(lo_reg), 64'd42);
    check("mul_hi", 64'(hi_reg), 64'd0);
    check("mul_r9_kept", 64'(r_file[9]), 64'd77);

    cur_test = "div";
    preload(4'd3, 32'd47); preload(4'd2, 32'd5);
    issue(OP_DIV, 4'd9, 4'd3, 4'd2);
    push_wide(OP_DIV, 16'h0008, 16'h0004);
    wait_drain(20);
    check("div_lo", 64'(lo_reg), 64'd9);
    check("div_hi", 64'(hi_reg), 64'd2);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "global timeout");
  end

endmodule
